// File: rtl/usb_tx_serializer_if.sv
// Byte-in / bit-out bus of the USB transmit serializer.
// master: packet source and bit-stuffer side; slave: the serializer.
interface usb_tx_serializer_if;
    logic       txStart;
    logic [1:0] txCrcMode;
    logic [7:0] txData;
    logic       txDataValid;
    logic       txIsLastByte;
    logic       txDataReady;
    logic       bitStall;
    logic       txBit;
    logic       txBitValid;
    logic       txBusy;
    logic       txDone;
    logic       txUnderrun;

    modport master (
        output txStart, txCrcMode, txData, txDataValid, txIsLastByte, bitStall,
        input  txDataReady, txBit, txBitValid, txBusy, txDone, txUnderrun
    );

    modport slave (
        input  txStart, txCrcMode, txData, txDataValid, txIsLastByte, bitStall,
        output txDataReady, txBit, txBitValid, txBusy, txDone, txUnderrun
    );
endinterface

// File: rtl/usb_tx_serializer.sv
// USB transmit packet serializer: PID + payload bytes go out LSb first, one bit
// per non-stalled cycle, followed by the inverted CRC5/CRC16 remainder MSb first.
module usb_tx_serializer (
    input  logic                clk12,
    input  logic                RST_N,
    usb_tx_serializer_if.slave  bus
);

    typedef enum logic [2:0] {
        StIdle,
        StPrime,
        StShift,
        StCrc,
        StFinish
    } state_e;

    localparam logic [1:0] ModeNone  = 2'd0;
    localparam logic [1:0] ModeCrc5  = 2'd1;
    localparam logic [1:0] ModeCrc16 = 2'd2;

    state_e      state_q, state_d;
    logic [7:0]  sr_q, sr_d;
    logic        sr_last_q, sr_last_d;     // byte in sr carried txIsLastByte
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  hold_q, hold_d;
    logic        full_q, full_d;
    logic        hold_last_q, hold_last_d;
    logic        last_seen_q, last_seen_d; // no more bytes accepted this packet
    logic [15:0] crc_q, crc_d;
    logic [3:0]  crc_cnt_q, crc_cnt_d;
    logic [1:0]  mode_q, mode_d;
    logic        pid_q, pid_d;             // sr holds the PID; excluded from CRC
    logic        underrun_q, underrun_d;

    logic        data_ready;
    logic        accept;
    logic        tx_bit;
    logic        tx_bit_valid;
    logic        tx_done;
    logic        fb;
    logic [15:0] crc_next;

    // CRC register advanced by the bit currently on the line; CRC5 uses bits [4:0] only
    always_comb begin
        fb       = ((mode_q == ModeCrc16) ? crc_q[15] : crc_q[4]) ^ sr_q[0];
        crc_next = {crc_q[14] ^ fb, crc_q[13:2], crc_q[1] ^ fb, crc_q[0], fb};
    end

    // Next-state logic, handshake and serial outputs
    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        sr_last_d    = sr_last_q;
        bit_cnt_d    = bit_cnt_q;
        hold_d       = hold_q;
        full_d       = full_q;
        hold_last_d  = hold_last_q;
        last_seen_d  = last_seen_q;
        crc_d        = crc_q;
        crc_cnt_d    = crc_cnt_q;
        mode_d       = mode_q;
        pid_d        = pid_q;
        underrun_d   = 1'b0;
        data_ready   = 1'b0;
        accept       = 1'b0;
        tx_bit       = 1'b0;
        tx_bit_valid = 1'b0;
        tx_done      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.txStart) begin
                    mode_d      = (bus.txCrcMode == 2'd3) ? ModeNone : bus.txCrcMode;
                    crc_d       = 16'hFFFF;
                    pid_d       = 1'b0;
                    full_d      = 1'b0;
                    last_seen_d = 1'b0;
                    sr_last_d   = 1'b0;
                    bit_cnt_d   = 3'd0;
                    state_d     = StPrime;
                end
            end

            StPrime: begin
                data_ready = 1'b1;
                accept     = bus.txDataValid;
                if (accept) begin
                    sr_d        = bus.txData;
                    sr_last_d   = bus.txIsLastByte;
                    last_seen_d = bus.txIsLastByte;
                    pid_d       = 1'b1;
                    bit_cnt_d   = 3'd0;
                    state_d     = StShift;
                end
            end

            StShift: begin
                tx_bit       = sr_q[0];
                tx_bit_valid = 1'b1;
                data_ready   = !full_q && !last_seen_q;
                accept       = bus.txDataValid && data_ready;
                // The handshake keeps running while the line is stalled
                if (accept) begin
                    hold_d      = bus.txData;
                    hold_last_d = bus.txIsLastByte;
                    full_d      = 1'b1;
                    last_seen_d = bus.txIsLastByte;
                end
                if (!bus.bitStall) begin
                    sr_d      = {1'b0, sr_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (!pid_q) begin
                        crc_d = crc_next;
                    end
                    if (bit_cnt_q == 3'd7) begin
                        if (full_q) begin
                            sr_d      = hold_q;
                            sr_last_d = hold_last_q;
                            full_d    = 1'b0;
                            pid_d     = 1'b0;
                        end else if (accept) begin
                            // Byte arriving on the final bit goes straight to sr
                            sr_d      = bus.txData;
                            sr_last_d = bus.txIsLastByte;
                            full_d    = 1'b0;
                            pid_d     = 1'b0;
                        end else if (sr_last_q) begin
                            if (mode_q == ModeNone) begin
                                state_d = StFinish;
                            end else begin
                                crc_cnt_d = (mode_q == ModeCrc5) ? 4'd4 : 4'd15;
                                state_d   = StCrc;
                            end
                        end else begin
                            underrun_d  = 1'b1;
                            full_d      = 1'b0;
                            last_seen_d = 1'b0;
                            state_d     = StIdle;
                        end
                    end
                end
            end

            StCrc: begin
                tx_bit       = ~crc_q[crc_cnt_q];
                tx_bit_valid = 1'b1;
                if (!bus.bitStall) begin
                    if (crc_cnt_q == 4'd0) begin
                        state_d = StFinish;
                    end else begin
                        crc_cnt_d = crc_cnt_q - 4'd1;
                    end
                end
            end

            StFinish: begin
                tx_done = 1'b1;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset drops straight back to idle
    always_ff @(posedge clk12 or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= StIdle;
            sr_q        <= 8'd0;
            sr_last_q   <= 1'b0;
            bit_cnt_q   <= 3'd0;
            hold_q      <= 8'd0;
            full_q      <= 1'b0;
            hold_last_q <= 1'b0;
            last_seen_q <= 1'b0;
            crc_q       <= 16'hFFFF;
            crc_cnt_q   <= 4'd0;
            mode_q      <= ModeNone;
            pid_q       <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            sr_last_q   <= sr_last_d;
            bit_cnt_q   <= bit_cnt_d;
            hold_q      <= hold_d;
            full_q      <= full_d;
            hold_last_q <= hold_last_d;
            last_seen_q <= last_seen_d;
            crc_q       <= crc_d;
            crc_cnt_q   <= crc_cnt_d;
            mode_q      <= mode_d;
            pid_q       <= pid_d;
            underrun_q  <= underrun_d;
        end
    end

    // Outputs are decoded from state so reset clears them without waiting for a clock
    assign bus.txDataReady = data_ready;
    assign bus.txBit       = tx_bit;
    assign bus.txBitValid  = tx_bit_valid;
    assign bus.txBusy      = (state_q != StIdle);
    assign bus.txDone      = tx_done;
    assign bus.txUnderrun  = underrun_q;

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Self-checking bench for usb_tx_serializer: expected bit streams are queued
// from a bench-side CRC model, and CRC-carrying packets are re-checked by a
// receiver-style residual computation.
module tb_usb_tx_serializer;

    logic clk12 = 1'b0;
    logic RST_N = 1'b0;

    usb_tx_serializer_if bus ();

    usb_tx_serializer dut (
        .clk12 (clk12),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 clk12 = ~clk12;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] pkt [8];
    int         pkt_n;
    logic       exp_q [$];

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b,
                                             input logic [1:0] m);
        logic        f;
        logic [15:0] n;
        if (m == 2'd2) begin
            f = c[15] ^ b;
            n = {c[14:0], 1'b0};
            if (f) n = n ^ 16'h8005;
        end else begin
            f = c[4] ^ b;
            n = {11'd0, c[3:0], 1'b0};
            if (f) n = n ^ 16'h0005;
        end
        return n;
    endfunction

    task automatic drive_idle();
        bus.txStart      = 1'b0;
        bus.txCrcMode    = 2'd0;
        bus.txData       = 8'd0;
        bus.txDataValid  = 1'b0;
        bus.txIsLastByte = 1'b0;
        bus.bitStall     = 1'b0;
    endtask

    // Sends pkt[0..pkt_n-1] and checks the serial stream against the queue.
    // starve: only the PID is offered. abort_after > 0: return mid-packet.
    task automatic run_packet(input string name, input logic [1:0] mode, input int stall_pct,
                              input bit starve, input bit poke_start, input int abort_after);
        logic [1:0]  em;
        logic [15:0] c;
        logic [15:0] rc;
        int nb, nexp, idx, nbits, span, stalls, cyc, acc_cyc, first_cyc, last_cyc, end_cyc;
        bit seen_done, seen_under, prev_stalled;
        logic prev_bit, got;

        em = (mode == 2'd3) ? 2'd0 : mode;
        nb = starve ? 1 : pkt_n;
        if (starve) em = 2'd0;
        c = (em == 2'd2) ? 16'hFFFF : 16'h001F;
        exp_q.delete();
        for (int i = 0; i < nb; i++) begin
            for (int k = 0; k < 8; k++) begin
                exp_q.push_back(pkt[i][k]);
                if (i > 0) c = crc_step(c, pkt[i][k], em);
            end
        end
        if (em == 2'd1) for (int k = 4; k >= 0; k--) exp_q.push_back(~c[k]);
        if (em == 2'd2) for (int k = 15; k >= 0; k--) exp_q.push_back(~c[k]);
        nexp = exp_q.size();
        rc = (em == 2'd2) ? 16'hFFFF : 16'h001F;

        idx = 0; nbits = 0; span = 0; stalls = 0; acc_cyc = -1; first_cyc = -1;
        last_cyc = -1; end_cyc = -1; seen_done = 0; seen_under = 0; prev_stalled = 0;
        prev_bit = 1'b0;

        @(posedge clk12); #1;
        bus.txStart   = 1'b1;
        bus.txCrcMode = mode;
        @(posedge clk12); #1;
        bus.txStart   = 1'b0;
        n_tests++;
        if (bus.txDataReady !== 1'b1 || bus.txBusy !== 1'b1 || bus.txBitValid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s ready_latency: ready=%b busy=%b valid=%b, need 1 1 0",
                     name, bus.txDataReady, bus.txBusy, bus.txBitValid);
        end

        for (cyc = 0; cyc < 2000 && !seen_done && !seen_under; cyc++) begin
            if (idx < pkt_n && !(starve && idx >= 1)) begin
                bus.txDataValid  = 1'b1;
                bus.txData       = pkt[idx];
                bus.txIsLastByte = (idx == pkt_n - 1);
            end else begin
                bus.txDataValid  = 1'b0;
                bus.txIsLastByte = 1'b0;
            end
            bus.bitStall = ($urandom_range(99) < stall_pct);
            bus.txStart  = poke_start && (nbits == 3);
            @(negedge clk12);
            if (bus.txDataValid && bus.txDataReady) begin
                if (idx == 0) acc_cyc = cyc;
                idx++;
            end
            if (bus.txDone) begin
                seen_done = 1;
                end_cyc   = cyc;
            end
            if (bus.txUnderrun) begin
                seen_under = 1;
                end_cyc    = cyc;
                n_tests++;
                if (bus.txBusy !== 1'b0 || bus.txBitValid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s underrun_idle: busy=%b valid=%b, need 0 0",
                             name, bus.txBusy, bus.txBitValid);
                end
            end
            if (bus.txBitValid) begin
                if (first_cyc < 0) first_cyc = cyc;
                span++;
                if (prev_stalled) begin
                    n_tests++;
                    if (bus.txBit !== prev_bit) begin
                        n_fail++;
                        $display("FAIL %s stall_hold: bit=%b, need %b", name, bus.txBit,
                                 prev_bit);
                    end
                end
                if (!bus.bitStall) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL %s extra_bit: bit %0d=%b, need no bit", name, nbits,
                                 bus.txBit);
                    end else begin
                        got = exp_q.pop_front();
                        if (bus.txBit !== got) begin
                            n_fail++;
                            $display("FAIL %s bit%0d: got %b, need %b", name, nbits,
                                     bus.txBit, got);
                        end
                    end
                    if (nbits >= 8) rc = crc_step(rc, bus.txBit, em);
                    nbits++;
                    last_cyc = cyc;
                end else begin
                    stalls++;
                end
                prev_stalled = bus.bitStall;
                prev_bit     = bus.txBit;
            end else begin
                prev_stalled = 0;
            end
            if (abort_after > 0 && nbits == abort_after) return;
            @(posedge clk12); #1;
        end
        drive_idle();

        n_tests++;
        if (!seen_done && !seen_under) begin
            n_fail++;
            $display("FAIL %s timeout: no txDone/txUnderrun within 2000 cycles, need one", name);
        end
        n_tests++;
        if (seen_done !== !starve || seen_under !== starve) begin
            n_fail++;
            $display("FAIL %s outcome: done=%b underrun=%b, need done=%b underrun=%b",
                     name, seen_done, seen_under, !starve, starve);
        end
        n_tests++;
        if (nbits != nexp || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s bit_count: got %0d, need %0d", name, nbits, nexp);
        end
        n_tests++;
        if (first_cyc != acc_cyc + 1 || end_cyc != last_cyc + 1 || span != nbits + stalls) begin
            n_fail++;
            $display("FAIL %s timing: acc=%0d first=%0d last=%0d end=%0d span=%0d, need %0d+1 %0d+1 %0d",
                     name, acc_cyc, first_cyc, last_cyc, end_cyc, span, acc_cyc, last_cyc,
                     nbits + stalls);
        end
        if (em != 2'd0) begin
            n_tests++;
            if (rc != ((em == 2'd2) ? 16'h800D : 16'h000C)) begin
                n_fail++;
                $display("FAIL %s crc_residual: got %h, need %h", name, rc,
                         (em == 2'd2) ? 16'h800D : 16'h000C);
            end
        end
        @(negedge clk12);
        n_tests++;
        if (bus.txDone !== 1'b0 || bus.txUnderrun !== 1'b0 || bus.txBusy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after_end: done=%b underrun=%b busy=%b, need 0 0 0", name,
                     bus.txDone, bus.txUnderrun, bus.txBusy);
        end
        @(posedge clk12); #1;
    endtask

    task automatic check_outputs_zero(input string name);
        n_tests++;
        if ({bus.txBit, bus.txBitValid, bus.txBusy, bus.txDataReady, bus.txDone,
             bus.txUnderrun} !== 6'b0) begin
            n_fail++;
            $display("FAIL %s outputs: bit=%b valid=%b busy=%b ready=%b done=%b underrun=%b, need all 0",
                     name, bus.txBit, bus.txBitValid, bus.txBusy, bus.txDataReady, bus.txDone,
                     bus.txUnderrun);
        end
    endtask

    task automatic test_reset();
        drive_idle();
        RST_N = 1'b0;
        repeat (3) @(posedge clk12);
        #1;
        check_outputs_zero("reset_held");
        RST_N = 1'b1;
        repeat (2) @(posedge clk12);
        #1;
        check_outputs_zero("idle_after_reset");
    endtask

    task automatic test_ack();
        pkt[0] = 8'hD2; pkt_n = 1;
        run_packet("ack", 2'd0, 0, 0, 0, 0);
    endtask

    task automatic test_empty_data0();
        pkt[0] = 8'hC3; pkt_n = 1;
        run_packet("empty_data0", 2'd2, 0, 0, 0, 0);
    endtask

    task automatic test_setup_token();
        pkt[0] = 8'h2D; pkt[1] = 8'h00; pkt[2] = 8'h10; pkt_n = 3;
        run_packet("setup_crc5", 2'd1, 0, 0, 1, 0);
    endtask

    task automatic test_back_to_back_stall();
        pkt[0] = 8'h4B; pkt[1] = 8'h00; pkt[2] = 8'h01; pkt[3] = 8'h02; pkt[4] = 8'h03;
        pkt_n = 5;
        run_packet("data1_stall", 2'd2, 20, 0, 0, 0);
        pkt[0] = 8'hC3; pkt[1] = 8'hA5; pkt[2] = 8'h5A; pkt[3] = 8'hFF; pkt_n = 4;
        run_packet("data0_nostall", 2'd2, 0, 0, 0, 0);
    endtask

    task automatic test_starvation();
        pkt[0] = 8'hC3; pkt[1] = 8'h00; pkt_n = 2;
        run_packet("starve", 2'd2, 0, 1, 0, 0);
    endtask

    task automatic test_reset_mid_crc();
        pkt[0] = 8'h4B; pkt[1] = 8'h11; pkt_n = 2;
        run_packet("data_abort", 2'd2, 0, 0, 0, 20);
        drive_idle();
        #2;
        RST_N = 1'b0;
        #1;
        check_outputs_zero("reset_mid_crc");
        @(posedge clk12); #1;
        RST_N = 1'b1;
        @(posedge clk12); #1;
        check_outputs_zero("idle_after_abort");
        pkt[0] = 8'hD2; pkt_n = 1;
        run_packet("ack_mode3", 2'd3, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_ack();
        test_empty_data0();
        test_setup_token();
        test_back_to_back_stall();
        test_starvation();
        test_reset_mid_crc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_tx_serializer.md
# usb_tx_serializer

Transmit-side packet serializer for the SIE. It accepts packet bytes over a valid/ready handshake, with the PID byte first, and emits them one bit per cycle, LSb first, toward the bit stuffer / NRZI encoder. While serializing, it computes the USB CRC5 or CRC16 over all bytes after the PID and appends the inverted remainder MSb first. Its output is bit-for-bit what the receive-side CRC checker validates.

## Interface
Parameters:
- none; CRC polynomials and seed are fixed by USB 2.0.

Ports:
- `clk12`  in  1  12 MHz bit clock; all logic on the rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `txStart`  in  1  pulse; starts a packet. Ignored unless idle.
- `txCrcMode`  in  2  sampled on an accepted `txStart`: 0 = no CRC (handshake), 1 = CRC5 (token/SOF), 2 = CRC16 (data), 3 = treated as 0.
- `txData`  in  8  packet byte.
- `txDataValid`  in  1  `txData` valid.
- `txIsLastByte`  in  1  qualifies `txData`; marks the final payload byte.
- `txDataReady`  out  1  holding register empty; a byte transfers when `txDataValid && txDataReady`.
- `bitStall`  in  1  downstream stall (stuff bit being inserted). Holds the current bit; no shift, no CRC update.
- `txBit`  out  1  serial data bit.
- `txBitValid`  out  1  `txBit` carries a packet bit.
- `txBusy`  out  1  packet in progress.
- `txDone`  out  1  one-cycle pulse after the last bit leaves.
- `txUnderrun`  out  1  one-cycle pulse on a byte starvation abort.

## Operation
- Storage: 8-bit shift register (`sr`), 3-bit bit counter, 8-bit holding register with `full` and `last` flags, 16-bit `crcBuf`, 4-bit CRC counter, and the latched CRC mode.

States:
- **IDLE**
  - `txBusy`, `txBitValid`, and `txDataReady` are 0.
  - On `txStart`: latch the mode, set `crcBuf` to 16'hFFFF, clear the PID flag, go to **PRIME**.
- **PRIME**
  - `txDataReady` = 1.
  - The first accepted byte (the PID) loads `sr` directly; go to **SHIFT** with the PID flag set.
- **SHIFT**
  - Drives `txBit = sr[0]` and `txBitValid = 1`.
  - On each non-stalled cycle: shift `sr` right and increment the counter.
  - Outside the PID byte, also update the CRC with the bit:
    - Feedback `fb = crcBuf[4]^bit` for CRC5, `crcBuf[15]^bit` for CRC16.
    - `crcBuf <= {crcBuf[14]^fb, crcBuf[13:2], crcBuf[1]^fb, crcBuf[0], fb}`.
  - At bit 7 (non-stalled):
    - If `full`: move the holding register into `sr`, clear `full`, clear the PID flag.
    - Otherwise, if the current byte was last:
      - mode 0 → **FINISH**;
      - else → **CRC**, with the counter set to 4 (CRC5) or 15 (CRC16).
    - Otherwise → pulse `txUnderrun` and go to **IDLE**.
  - `txDataReady = !full && !lastSeen`, where `lastSeen` is set once a byte with `txIsLastByte` is accepted.
- **CRC**
  - Drives `txBit = ~crcBuf[counter]` and `txBitValid = 1`.
  - The counter decrements on non-stalled cycles. The CRC is frozen in this state.
  - After index 0 is emitted → **FINISH**.
- **FINISH**
  - Pulse `txDone`, go to **IDLE**.

Rules:
- A PID byte flagged `txIsLastByte` ends the packet after the PID. With CRC enabled, the appended CRC is then over zero bytes.
- `txStart` while busy is ignored.
- `RST_N` low at any time: immediately go to **IDLE**, clear all flags, and force every output to 0.

## Timing
- Reset values: `txBit`, `txBitValid`, `txBusy`, `txDataReady`, `txDone`, and `txUnderrun` are all 0.
- Latency:
  - `txStart` at cycle 0 → `txDataReady` = 1 at cycle 1.
  - PID accepted at cycle n → its first bit is on `txBit` at cycle n+1.
- Throughput:
  - Exactly one bit per non-stalled cycle with no bubbles, provided each next byte is accepted before bit 7 of the current byte.
  - `txDataReady` reasserts the cycle after the holding register drains.
- `bitStall` freezes all state except the handshake. A byte may still be accepted into the holding register while stalled.
- Packet length in non-stalled cycles: 8·N bits, plus 5 (CRC5) or 16 (CRC16). `txDone` follows the last bit by one cycle.
- `txBusy` = 1 in every state except **IDLE**. `txBitValid` = 1 only in **SHIFT** and **CRC**.

## Test plan
- ACK, mode 0, PID 0xD2 marked last → bits 0,1,0,0,1,0,1,1 on 8 consecutive cycles, then `txDone`. No `txUnderrun`.
- Empty DATA0, mode 2, 0xC3 marked last → bits 1,1,0,0,0,0,1,1, then 16 zero bits (inverted all-ones seed), then `txDone`.
- SETUP token, mode 1: 0x2D, 0x00, 0x10 (last).
  - Every bit after the PID is fed into `usb_crc` (reset at the PID, `rxUseCRC16` = 0).
  - Required: `validCRC` = 1 after the 5th CRC bit; 29 bits total.
- DATA1, mode 2: 0x4B, 0x00, 0x01, 0x02, 0x03 (last), with `bitStall` pulsed at random ~20%.
  - Required: each bit holds while stalled, 56 valid bits after filtering stalls.
  - Required: the `usb_crc` checker reports `validCRC` = 1.
- Starvation: DATA0 with 0xC3, then withhold `txDataValid` → `txUnderrun` pulses in the cycle after PID bit 7; **IDLE**; `txDone` stays 0.
- Drive `RST_N` low mid-CRC16 → all outputs 0 immediately. A following ACK transmits correctly.
